// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: FSM encodings, character constants and FIFO level-width helper for the UART echo controller.
package uart_ctrl_pkg;
    typedef enum logic {R_IDLE, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_BUSY, T_DONE} tx_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH-entry byte FIFO with registered occupancy and a combinational head.
module uart_byte_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              head,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    assign head  = mem[rptr];
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: RX->TX echo sequencer with error filtering and saturating counters.
// Define UART_ECHO_CRLF_EN to follow every echoed CR with an inserted LF.
module uart_echo_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    cnt_clr,
    input  logic                    rxrdy,
    input  logic [7:0]              rx_data,
    input  logic                    ferr,
    input  logic                    perr,
    output logic                    clr,
    input  logic                    txrdy,
    output logic                    load,
    output logic [7:0]              tx_data,
    output logic [lvl_w(DEPTH)-1:0] fifo_level,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    irq
);
    rx_state_t  rstate, rnext;
    tx_state_t  tstate, tnext;
    logic       cap, cap_bad, arm, go, avail, push, pop, full, empty, bad, drop;
    logic [7:0] cap_data, head, tx_next;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (cap_data),
        .head   (head),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

    // clr marks the capture cycle; a pop in that same cycle frees a slot even at full
    assign bad  = clr & cap_bad;
    assign push = clr & ~cap_bad & (~full | pop);
    assign drop = clr & ~cap_bad & full & ~pop;

`ifdef UART_ECHO_CRLF_EN
    logic lf_pend, lf_cur;

    assign avail   = lf_pend | ~empty;
    assign tx_next = lf_pend ? CHAR_LF : head;
    assign pop     = load & ~lf_cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lf_pend <= 1'b0;
            lf_cur  <= 1'b0;
        end else if (go) begin
            lf_cur  <= lf_pend;
            lf_pend <= 1'b0;
        end else if (pop && tx_data == CHAR_CR) begin
            lf_pend <= 1'b1;
        end
    end
`else
    assign avail   = ~empty;
    assign tx_next = head;
    assign pop     = load;
`endif

    always_comb begin
        rnext = rstate;
        cap   = 1'b0;
        case (rstate)
            R_IDLE: begin
                cap   = rxrdy;
                rnext = rxrdy ? R_WAIT : R_IDLE;
            end
            default: rnext = rxrdy ? R_WAIT : R_IDLE;
        endcase
    end

    always_comb begin
        tnext = tstate;
        go    = 1'b0;
        case (tstate)
            T_IDLE: begin
                go    = enable & txrdy & avail;
                tnext = go ? T_BUSY : T_IDLE;
            end
            T_BUSY:  tnext = txrdy ? T_BUSY : T_DONE;
            T_DONE:  tnext = txrdy ? T_IDLE : T_DONE;
            default: tnext = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate   <= R_IDLE;
            tstate   <= T_IDLE;
            clr      <= 1'b0;
            cap_data <= 8'h00;
            cap_bad  <= 1'b0;
            arm      <= 1'b0;
            load     <= 1'b0;
            tx_data  <= 8'h00;
            irq      <= 1'b0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            rstate <= rnext;
            tstate <= tnext;
            clr    <= cap;
            arm    <= go;
            load   <= arm;
            irq    <= bad | drop;
            if (cap) begin
                cap_data <= rx_data;
                cap_bad  <= ferr | perr;
            end
            if (go) tx_data <= tx_next;
            // saturating; cnt_clr beats a same-cycle increment
            err_cnt  <= cnt_clr ? '0 : err_cnt + CNT_W'(bad & ~&err_cnt);
            drop_cnt <= cnt_clr ? '0 : drop_cnt + CNT_W'(drop & ~&drop_cnt);
        end
    end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: vector table, corner sequences and randomized rounds against a queue-based echo model.
module tb_uart_echo_ctrl;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n, enable, cnt_clr, rxrdy, ferr, perr, txrdy, clr, load, irq;
    logic [7:0] rx_data, tx_data, err_cnt, drop_cnt;
    logic [3:0] fifo_level;

    int         n_cmp = 0, n_bad = 0, cyc = 0, irq_n = 0, base = 0;
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ld;
        logic [7:0] err;
    } vec_t;
    vec_t tbl[6];

    uart_echo_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cnt_clr   (cnt_clr),
        .rxrdy     (rxrdy),
        .rx_data   (rx_data),
        .ferr      (ferr),
        .perr      (perr),
        .clr       (clr),
        .txrdy     (txrdy),
        .load      (load),
        .tx_data   (tx_data),
        .fifo_level(fifo_level),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (irq) irq_n <= irq_n + 1;

    // tx_engine stand-in: latches on load, busy for a random frame time
    initial begin
        txrdy = 1'b1;
        forever begin
            @(negedge clk);
            if (load) begin
                got.push_back(tx_data);
                got_cyc.push_back(cyc);
                txrdy = 1'b0;
                repeat ($urandom_range(6, 2)) @(negedge clk);
                txrdy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d want finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int gb(input int i);
        return (base + i < got.size()) ? int'(got[base + i]) : -1;
    endfunction

    task automatic send(input logic [7:0] d, input logic fe, input logic pe, input logic cc,
                        output int dly, output int t0);
        @(negedge clk);
        rxrdy = 1'b1; rx_data = d; ferr = fe; perr = pe;
        t0 = cyc;
        dly = -1;
        for (int i = 1; i <= 6 && dly < 0; i++) begin
            @(negedge clk);
            if (clr) begin
                dly = i;
                cnt_clr = cc;
            end
        end
        rxrdy = 1'b0; ferr = 1'b0; perr = 1'b0;
        if (dly < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL clr_timeout: got no clr want clr for byte %0h", d);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_loads(input int n, input int budget);
        int i = 0;
        while (got.size() - base < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (got.size() - base < n) chk("load_timeout", got.size() - base, n);
    endtask

    task automatic pulse_cnt_clr();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int         dly, t0, i0, occ, m_err, m_drop, n;
        logic [7:0] d;
        logic       fe, pe;

        tbl[0] = '{8'h41, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[3] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'd3};
        tbl[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'd3};
        tbl[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'd3};

        reset_n = 1'b0; enable = 1'b0; cnt_clr = 1'b0; rxrdy = 1'b0;
        rx_data = 8'h00; ferr = 1'b0; perr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clr", int'(clr), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte: clr one cycle after rxrdy, load four cycles after rxrdy
        enable = 1'b1;
        base = got.size();
        send(8'h41, 1'b0, 1'b0, 1'b0, dly, t0);
        chk("single_clr_delay", dly, 1);
        wait_loads(1, 40);
        chk("single_latency", (got_cyc.size() > base) ? got_cyc[base] - t0 : -1, 4);
        chk("single_data", gb(0), 'h41);
        repeat (3) @(negedge clk);
        chk("single_level", int'(fifo_level), 0);
        repeat (10) @(negedge clk);

        foreach (tbl[i]) begin
            base = got.size();
            i0 = irq_n;
            send(tbl[i].d, tbl[i].fe, tbl[i].pe, 1'b0, dly, t0);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_loads", i), got.size() - base, int'(tbl[i].ld));
            if (tbl[i].ld) chk($sformatf("vec%0d_data", i), gb(0), int'(tbl[i].d));
            chk($sformatf("vec%0d_err", i), int'(err_cnt), int'(tbl[i].err));
            chk($sformatf("vec%0d_irq", i), irq_n - i0, tbl[i].ld ? 0 : 1);
        end

        pulse_cnt_clr();
        chk("cnt_clr_err", int'(err_cnt), 0);

        // backpressure: 10 bytes held, 8 kept, 2 dropped
        enable = 1'b0;
        base = got.size();
        i0 = irq_n;
        for (int i = 0; i < 10; i++) send(8'(8'h10 + i), 1'b0, 1'b0, 1'b0, dly, t0);
        chk("bp_level", int'(fifo_level), 8);
        chk("bp_drop", int'(drop_cnt), 2);
        chk("bp_irq", irq_n - i0, 2);
        // full FIFO: capture lands on the first pop cycle and must still be accepted
        @(negedge clk); enable = 1'b1;
        @(negedge clk); rxrdy = 1'b1; rx_data = 8'hEE;
        @(negedge clk);
        chk("fb_clr", int'(clr), 1);
        chk("fb_load", int'(load), 1);
        rxrdy = 1'b0;
        @(negedge clk);
        chk("fb_level", int'(fifo_level), 8);
        repeat (2) @(negedge clk);
        chk("fb_drop", int'(drop_cnt), 2);
        chk("fb_irq", irq_n - i0, 2);
        wait_loads(9, 300);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_order%0d", i), gb(i), 'h10 + i);
        chk("fb_tail", gb(8), 'hEE);
        repeat (20) @(negedge clk);

        // saturation, then cnt_clr racing an increment
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b1, 1'($urandom), 1'b0, dly, t0);
        chk("sat_err", int'(err_cnt), 'hFF);
        send(8'h00, 1'b0, 1'b1, 1'b1, dly, t0);
        chk("clr_priority", int'(err_cnt), 0);

        base = got.size();
        send(8'h0D, 1'b0, 1'b0, 1'b0, dly, t0);
        send(8'h42, 1'b0, 1'b0, 1'b0, dly, t0);
`ifdef UART_ECHO_CRLF_EN
        exp_q = '{8'h0D, 8'h0A, 8'h42};
`else
        exp_q = '{8'h0D, 8'h42};
`endif
        wait_loads(exp_q.size(), 200);
        repeat (30) @(negedge clk);
        chk("crlf_count", got.size() - base, exp_q.size());
        foreach (exp_q[i]) chk($sformatf("crlf_byte%0d", i), gb(i), int'(exp_q[i]));

        for (int r = 0; r < 6; r++) begin
            pulse_cnt_clr();
            enable = 1'b0;
            base = got.size();
            exp_q.delete();
            i0 = irq_n; occ = 0; m_err = 0; m_drop = 0;
            n = $urandom_range(12, 3);
            for (int i = 0; i < n; i++) begin
                d  = 8'($urandom);
                fe = $urandom_range(7, 0) == 0;
                pe = $urandom_range(7, 0) == 0;
                send(d, fe, pe, 1'b0, dly, t0);
                if (fe | pe) m_err++;
                else if (occ < DEPTH) begin
                    occ++;
                    exp_q.push_back(d);
`ifdef UART_ECHO_CRLF_EN
                    if (d == 8'h0D) exp_q.push_back(8'h0A);
`endif
                end else m_drop++;
            end
            chk($sformatf("rnd%0d_level", r), int'(fifo_level), occ);
            chk($sformatf("rnd%0d_err", r), int'(err_cnt), m_err);
            chk($sformatf("rnd%0d_drop", r), int'(drop_cnt), m_drop);
            chk($sformatf("rnd%0d_irq", r), irq_n - i0, m_err + m_drop);
            enable = 1'b1;
            wait_loads(exp_q.size(), 30 * exp_q.size() + 50);
            repeat (20) @(negedge clk);
            chk($sformatf("rnd%0d_count", r), got.size() - base, exp_q.size());
            foreach (exp_q[i]) chk($sformatf("rnd%0d_byte%0d", r, i), gb(i), int'(exp_q[i]));
        end

        // async reset while a frame is in flight with bytes queued
        send(8'h00, 1'b1, 1'b0, 1'b0, dly, t0);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(8'h31 + i), 1'b0, 1'b0, 1'b0, dly, t0);
        enable = 1'b1;
        for (int i = 0; i < 50 && !load; i++) @(negedge clk);
        chk("rm_load_seen", int'(load), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_clr", int'(clr), 0);
        chk("rm_load", int'(load), 0);
        chk("rm_tx_data", int'(tx_data), 0);
        chk("rm_irq", int'(irq), 0);
        chk("rm_level", int'(fifo_level), 0);
        chk("rm_err", int'(err_cnt), 0);
        chk("rm_drop", int'(drop_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        base = got.size();
        repeat (40) @(negedge clk);
        chk("rm_no_load", got.size() - base, 0);
        send(8'h77, 1'b0, 1'b0, 1'b0, dly, t0);
        wait_loads(1, 50);
        chk("rm_rearm", gb(0), 'h77);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
